// File: rtl/exp_pkg.sv
// Shared widths, fixed-point format and FSM encoding for the
// request arbiter in front of the shared exp engine.
package exp_pkg;

  localparam int X_W    = 16;
  localparam int R_W    = 18;
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first requester after the last accepted one
// wins, and the pointer only moves on an accept strobe.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    accept_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_id_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] last_q;
  logic           found;
  int             idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_o[idx]    = 1'b1;
        gnt_id_o      = IDW'(idx);
      end
    end
  end

  // NREQ-1 after reset so requester 0 is first in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
    end else if (accept_i) begin
      last_q <= gnt_id_o;
    end
  end

endmodule

// File: rtl/exp_req_arbiter.sv
// Serialises NREQ requesters onto one exp engine (IDLE/RUN/RSP).
// Define EXP_ARB_TIMEOUT_EN to add the TIMEOUT-cycle engine watchdog.
module exp_req_arbiter
  import exp_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*X_W-1:0]     req_x,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [R_W-1:0]          rsp_r,
  output logic                    rsp_err,
  input  logic                    rsp_ready,
  output logic                    eng_start,
  output logic [X_W-1:0]          eng_x,
  input  logic [R_W-1:0]          eng_r,
  input  logic                    eng_done,
  output logic                    eng_abort
);

  localparam int IDW = $clog2(NREQ);

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [IDW-1:0] id_q, id_d;
  logic [R_W-1:0] r_q, r_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            accept;
  logic            tmo;

  assign accept = (state_q == ST_IDLE) && (|req_valid) && !rst;

  rr_arbiter #(
    .NREQ     (NREQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_valid),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_d = (state_q == ST_RUN) ? cnt_q + CW'(1) : '0;
  assign tmo   = (state_q == ST_RUN) && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // a done on the timeout cycle wins, so no abort then
  assign eng_abort = tmo && !eng_done;
`else
  assign tmo       = 1'b0;
  assign eng_abort = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    id_d    = id_q;
    r_d     = r_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          x_d     = req_x[int'(gnt_id)*X_W +: X_W];
          id_d    = gnt_id;
        end
      end
      ST_RUN: begin
        if (eng_done) begin
          state_d = ST_RSP;
          r_d     = eng_r;
          err_d   = 1'b0;
        end else if (tmo) begin
          state_d = ST_RSP;
          r_d     = '0;
          err_d   = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      id_q    <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      id_q    <= id_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  // outputs are qualified by state so idle and reset read as all zero
  assign req_ready = accept ? gnt : '0;
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_r     = rsp_valid ? r_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  assign eng_start = (state_q == ST_RUN);
  assign eng_x     = eng_start ? x_q : '0;

endmodule
